// File: rtl/div_seq.sv
// Sequential restoring divider for DIV/DIVU: 32 iterations, result ready one edge after the last.
// Holds stall_req_out while busy; the result is held in END until start drops or annul flushes.
module div_seq #(
  parameter int DIV_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_start_in,
  input  logic               div_signed_in,
  input  logic               div_annul_in,
  input  logic [DIV_W-1:0]   div_src1_in,
  input  logic [DIV_W-1:0]   div_src2_in,
  output logic [2*DIV_W-1:0] div_result_out,
  output logic               div_ready_out,
  output logic               stall_req_out
);

  localparam int CNT_W = $clog2(DIV_W) + 1;
  localparam logic [DIV_W-1:0] L_ZERO = '0;

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [DIV_W-1:0]   r_dividend;
  logic [DIV_W-1:0]   r_divisor;
  logic [DIV_W:0]     r_rem;
  logic               r_qsign;
  logic               r_rsign;
  logic [2*DIV_W-1:0] r_result;
  logic               r_ready;

  logic               w_accept;
  logic               w_neg1;
  logic               w_neg2;
  logic               w_done;
  logic [DIV_W+1:0]   w_shift;
  logic [DIV_W+1:0]   w_trial;
  logic [DIV_W-1:0]   w_quot;
  logic [DIV_W-1:0]   w_remf;

  assign w_accept = div_start_in && !div_annul_in;
  assign w_neg1   = div_signed_in && div_src1_in[DIV_W-1];
  assign w_neg2   = div_signed_in && div_src2_in[DIV_W-1];
  assign w_done   = (r_cnt == CNT_W'(DIV_W));

  // Extra top bit of the trial difference is the borrow: set means restore.
  assign w_shift  = {r_rem, r_dividend[DIV_W-1]};
  assign w_trial  = w_shift - {2'b00, r_divisor};
  assign w_quot   = r_qsign ? (L_ZERO - r_dividend) : r_dividend;
  assign w_remf   = r_rsign ? (L_ZERO - r_rem[DIV_W-1:0]) : r_rem[DIV_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= FREE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FREE: begin
        if (w_accept) w_next = (div_src2_in == L_ZERO) ? BY_ZERO : ON;
      end
      ON: begin
        if (div_annul_in) w_next = FREE;
        else if (w_done)  w_next = END;
      end
      BY_ZERO: w_next = div_annul_in ? FREE : END;
      END: begin
        if (div_annul_in || !div_start_in) w_next = FREE;
      end
      default: w_next = FREE;
    endcase
  end

  always_comb begin
    stall_req_out = 1'b0;
    case (r_state)
      FREE:    stall_req_out = w_accept;
      ON:      stall_req_out = 1'b1;
      BY_ZERO: stall_req_out = 1'b1;
      default: stall_req_out = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_qsign    <= 1'b0;
      r_rsign    <= 1'b0;
      r_result   <= '0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        FREE: begin
          if (w_accept) begin
            r_dividend <= w_neg1 ? (L_ZERO - div_src1_in) : div_src1_in;
            r_divisor  <= w_neg2 ? (L_ZERO - div_src2_in) : div_src2_in;
            r_qsign    <= w_neg1 ^ w_neg2;
            r_rsign    <= w_neg1;
            r_rem      <= '0;
            r_cnt      <= '0;
          end
        end
        ON: begin
          if (div_annul_in) begin
            r_result <= '0;
            r_ready  <= 1'b0;
          end else if (!w_done) begin
            r_rem      <= w_trial[DIV_W+1] ? w_shift[DIV_W:0] : w_trial[DIV_W:0];
            r_dividend <= {r_dividend[DIV_W-2:0], ~w_trial[DIV_W+1]};
            r_cnt      <= r_cnt + CNT_W'(1);
          end else begin
            r_result <= {w_remf, w_quot};
            r_ready  <= 1'b1;
          end
        end
        BY_ZERO: begin
          r_result <= '0;
          r_ready  <= !div_annul_in;
        end
        END: begin
          if (div_annul_in || !div_start_in) begin
            r_result <= '0;
            r_ready  <= 1'b0;
          end
        end
        default: begin
          r_result <= '0;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign div_result_out = r_result;
  assign div_ready_out  = r_ready;

endmodule

// File: tb/tb_div_seq.sv
// Directed and random bench for div_seq against an arithmetic reference of DIV/DIVU.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        div_start_in;
  logic        div_signed_in;
  logic        div_annul_in;
  logic [31:0] div_src1_in;
  logic [31:0] div_src2_in;
  logic [63:0] div_result_out;
  logic        div_ready_out;
  logic        stall_req_out;

  int checks;
  int failures;

  div_seq #(.DIV_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .div_start_in   (div_start_in),
    .div_signed_in  (div_signed_in),
    .div_annul_in   (div_annul_in),
    .div_src1_in    (div_src1_in),
    .div_src2_in    (div_src2_in),
    .div_result_out (div_result_out),
    .div_ready_out  (div_ready_out),
    .stall_req_out  (stall_req_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Quotient truncates toward zero, remainder takes the dividend's sign; divide by zero yields 0.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint unsigned ma, mb, q, r;
    logic na, nb;
    logic [31:0] q32, r32;
    if (b == 32'd0) return 64'd0;
    na  = sgn && a[31];
    nb  = sgn && b[31];
    ma  = na ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
    mb  = nb ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
    q   = ma / mb;
    r   = ma % mb;
    q32 = q[31:0];
    r32 = r[31:0];
    if (na ^ nb) q32 = -q32;
    if (na)      r32 = -r32;
    return {r32, q32};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [63:0] exp_res, input string tag);
    int n;
    int lat;
    lat = (b == 32'd0) ? 2 : 34;
    div_start_in  = 1'b1;
    div_signed_in = sgn;
    div_src1_in   = a;
    div_src2_in   = b;
    #1;
    chk({tag, "_stall_start"}, {63'd0, stall_req_out}, 64'd1);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      div_src1_in   = $urandom;
      div_src2_in   = $urandom;
      div_signed_in = 1'($urandom_range(0, 1));
      if (div_ready_out) break;
      chk({tag, "_stall_busy"}, {63'd0, stall_req_out}, 64'd1);
    end
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_result"}, div_result_out, exp_res);
    chk({tag, "_stall_end"}, {63'd0, stall_req_out}, 64'd0);
    tick();
    chk({tag, "_hold_ready"}, {63'd0, div_ready_out}, 64'd1);
    chk({tag, "_hold_result"}, div_result_out, exp_res);
    div_start_in = 1'b0;
    tick();
    chk({tag, "_free_ready"}, {63'd0, div_ready_out}, 64'd0);
    chk({tag, "_free_result"}, div_result_out, 64'd0);
    chk({tag, "_free_stall"}, {63'd0, stall_req_out}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    div_start_in  = 1'b0;
    div_signed_in = 1'b0;
    div_annul_in  = 1'b0;
    div_src1_in   = '0;
    div_src2_in   = '0;
    repeat (2) tick();
    chk("reset_ready", {63'd0, div_ready_out}, 64'd0);
    chk("reset_result", div_result_out, 64'd0);
    chk("reset_stall", {63'd0, stall_req_out}, 64'd0);
    rst = 1'b1;
    tick();

    run_op(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, "u100_7");
    run_op(32'hFFFFFFF9, 32'h00000002, 1'b1, 64'hFFFFFFFF_FFFFFFFD, "s_m7_2");
    run_op(32'h00000007, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, "s_7_m2");
    run_op(32'd5, 32'd0, 1'b0, 64'd0, "divzero");
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, "s_ovf");

    // Annul after ten iterations
    div_start_in  = 1'b1;
    div_signed_in = 1'b0;
    div_src1_in   = 32'd100;
    div_src2_in   = 32'd7;
    repeat (11) tick();
    chk("annul_busy_stall", {63'd0, stall_req_out}, 64'd1);
    div_annul_in = 1'b1;
    div_start_in = 1'b0;
    tick();
    chk("annul_stall", {63'd0, stall_req_out}, 64'd0);
    chk("annul_ready", {63'd0, div_ready_out}, 64'd0);
    div_annul_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("annul_no_ready", {63'd0, div_ready_out}, 64'd0);
    end
    run_op(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, "after_annul");

    // Asynchronous reset mid-operation, away from any clock edge
    div_start_in  = 1'b1;
    div_signed_in = 1'b0;
    div_src1_in   = 32'd1000;
    div_src2_in   = 32'd3;
    repeat (6) tick();
    #2;
    rst          = 1'b0;
    div_start_in = 1'b0;
    #1;
    chk("arst_result", div_result_out, 64'd0);
    chk("arst_ready", {63'd0, div_ready_out}, 64'd0);
    chk("arst_stall", {63'd0, stall_req_out}, 64'd0);
    #2;
    rst = 1'b1;
    tick();
    run_op(32'hFFFFFFFF, 32'h00000010, 1'b0, 64'h0000000F_0FFFFFFF, "after_arst");

    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if (i == 0) ra = 32'h80000000;
      run_op(ra, rb, rs, ref_div(ra, rb, rs), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
